// File: rtl/led_pkg.sv
// Shared types and constants for the LED PWM / afterglow stage.
package led_pkg;
  localparam int LED_NUM = 4;
  localparam int PWM_W   = 8;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_ON   = 2'd1,
    ST_FADE = 2'd2
  } ch_state_e;

  // Unsigned subtract clamped at zero; the extra bit flags underflow.
  function automatic logic [PWM_W-1:0] sat_sub(input logic [PWM_W-1:0] a,
                                               input logic [PWM_W-1:0] b);
    logic [PWM_W:0] d;
    d = {1'b0, a} - {1'b0, b};
    sat_sub = d[PWM_W] ? '0 : d[PWM_W-1:0];
  endfunction
endpackage

// File: rtl/led_fade_pwm_if.sv
// Pattern/brightness in, PWM pin drive out, between chaser and LED stage.
interface led_fade_pwm_if;
  import led_pkg::*;
  logic [LED_NUM-1:0] led_in;
  logic [PWM_W-1:0]   bright;
  logic [LED_NUM-1:0] led_out;

  modport master (output led_in, output bright, input led_out);
  modport slave  (input led_in, input bright, output led_out);
endinterface

// File: rtl/led_fade_channel.sv
// One LED channel: OFF/ON(/FADE) FSM, working and period-latched duty, PWM compare.
// Afterglow logic is present only when LED_FADE_EN is defined.
module led_fade_channel
  import led_pkg::*;
`ifdef LED_FADE_EN
#(
  parameter int FADE_STEP = 16
)
`endif
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PWM_W-1:0] pwm_cnt,
  input  logic             period_end,
`ifdef LED_FADE_EN
  input  logic             fade_tick,
`endif
  input  logic             led_in,
  input  logic [PWM_W-1:0] bright,
  output logic             led_out
);
`ifdef LED_FADE_EN
  localparam logic [PWM_W-1:0] STEP = PWM_W'(FADE_STEP);
`endif

  ch_state_e        state, state_d;
  logic [PWM_W-1:0] duty, duty_d, duty_q;

  always_comb begin
    state_d = state;
    duty_d  = duty;
    case (state)
      ST_OFF: begin
        duty_d = '0;
        if (led_in) begin
          state_d = ST_ON;
          duty_d  = bright;
        end
      end
      ST_ON: begin
        if (led_in) begin
          duty_d = bright;
        end else begin
`ifdef LED_FADE_EN
          state_d = ST_FADE;
`else
          state_d = ST_OFF;
          duty_d  = '0;
`endif
        end
      end
`ifdef LED_FADE_EN
      ST_FADE: begin
        // Re-light takes priority over reaching zero in the same cycle.
        if (led_in) begin
          state_d = ST_ON;
          duty_d  = bright;
        end else begin
          if (fade_tick) duty_d = sat_sub(duty, STEP);
          if (duty_d == '0) state_d = ST_OFF;
        end
      end
`endif
      default: begin
        state_d = ST_OFF;
        duty_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_OFF;
      duty    <= '0;
      duty_q  <= '0;
      led_out <= 1'b0;
    end else begin
      state <= state_d;
      duty  <= duty_d;
      // Latch only at period end so a period never gets a runt pulse.
      if (period_end) duty_q <= duty;
      led_out <= (pwm_cnt < duty_q);
    end
  end
endmodule

// File: rtl/led_fade_pwm.sv
// LED PWM output stage: shared PWM/fade timebase plus one channel per LED.
// Define LED_FADE_EN to enable linear afterglow on switch-off.
module led_fade_pwm
  import led_pkg::*;
#(
  parameter int FADE_TICK = 500_000,
  parameter int FADE_STEP = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  led_fade_pwm_if.slave  bus
);
  if (FADE_TICK < 1) begin : g_chk_tick
    $error("FADE_TICK must be >= 1");
  end
  if (FADE_STEP < 1 || FADE_STEP > 255) begin : g_chk_step
    $error("FADE_STEP must be in 1..255");
  end

  logic [PWM_W-1:0]   pwm_cnt;
  logic               period_end;
  logic [LED_NUM-1:0] led_out_w;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pwm_cnt <= '0;
    else        pwm_cnt <= pwm_cnt + 1'b1;
  end

  assign period_end = (pwm_cnt == '1);

`ifdef LED_FADE_EN
  localparam int TW = (FADE_TICK > 1) ? $clog2(FADE_TICK) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(FADE_TICK - 1);

  logic [TW-1:0] tick_cnt;
  logic          fade_tick;

  // Free-running; not restarted on fade entry, so the first step lands anywhere in a tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    tick_cnt <= '0;
    else if (tick_cnt == TICK_LAST) tick_cnt <= '0;
    else                           tick_cnt <= tick_cnt + 1'b1;
  end

  assign fade_tick = (tick_cnt == TICK_LAST);
`endif

  for (genvar i = 0; i < LED_NUM; i++) begin : g_ch
    led_fade_channel
`ifdef LED_FADE_EN
      #(.FADE_STEP(FADE_STEP))
`endif
    u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .pwm_cnt    (pwm_cnt),
      .period_end (period_end),
`ifdef LED_FADE_EN
      .fade_tick  (fade_tick),
`endif
      .led_in     (bus.led_in[i]),
      .bright     (bus.bright),
      .led_out    (led_out_w[i])
    );
  end

  assign bus.led_out = led_out_w;
endmodule

// File: doc/led_fade_pwm.md
# led_fade_pwm

Per-channel PWM output stage that sits directly downstream of the 4-bit LED chaser. It consumes the chaser's on/off pattern and drives the board LED pins with a brightness-limited PWM waveform. When a channel is switched off, it decays linearly to dark ("afterglow") instead of cutting out abruptly.

## Interface
- `FADE_TICK`, default 500_000: clock cycles per fade step (10 ms at 50 MHz, 20 ns clock).
- `FADE_STEP`, default 16: duty decrement applied per fade tick.
- `clk`, input, 1: system clock, 50 MHz.
- `rst_n`, input, 1: asynchronous, active-low reset; clock is `clk`.
- `led_in`, input, 4: pattern from the chaser; 1 = channel lit.
- `bright`, input, 8: global duty ceiling, 0..255.
- `led_out`, output, 4: registered PWM drive to the pins; 1 = LED on.

## Operation
- `pwm_cnt` (8 bit) is free-running over 0..255 and wraps 255→0. The PWM period is 256 cycles.
- `tick_cnt` counts 0..FADE_TICK-1 and wraps. `fade_tick` is a one-cycle strobe when `tick_cnt == FADE_TICK-1`.
- Each channel i has:
  - a working duty `duty[i]` (8 bit),
  - a latched duty `duty_q[i]`,
  - a 3-state FSM: OFF, ON, FADE.
- OFF → ON when `led_in[i]=1`.
- ON:
  - `duty[i] <= bright` every cycle, so it tracks `bright` live.
  - ON → FADE when `led_in[i]=0`; `duty[i]` holds its current value.
- FADE:
  - On `fade_tick`, `duty[i] <= duty[i] - FADE_STEP`, saturating at 0.
  - FADE → ON when `led_in[i]=1`. The duty jumps to `bright` and the partial fade is discarded.
  - FADE → OFF on the cycle `duty[i]` becomes 0.
  - If `led_in[i]=1` and the duty reaches 0 in the same cycle, ON wins.
- OFF: `duty[i]=0`.
- `duty_q[i] <= duty[i]` only when `pwm_cnt==255`. Duty never changes mid-period, so there are no runt pulses.
- `led_out[i] <= (pwm_cnt < duty_q[i])`.
  - Duty 0 gives a constant 0.
  - Duty 255 gives 255/256 on.
  - 100% on is not reachable by design.
- `bright=0` with `led_in=1`: channel stays in ON and the output is dark.
- All comparisons are unsigned 8 bit. The decrement uses a 9-bit intermediate to detect underflow.

## Timing
- Reset values: `led_out=4'b0000`, `pwm_cnt=0`, `tick_cnt=0`, all `duty`/`duty_q`=0, all FSMs OFF.
- Reset is asynchronous: outputs go dark immediately on `rst_n` low, including mid-fade or mid-period.
- `led_in` rise to FSM ON / `duty` updated: 1 cycle.
- `duty` to `duty_q`: at the next `pwm_cnt==255`.
- `duty_q` to first `led_out` high: 1 cycle later, at `pwm_cnt==0` plus register delay.
- Worst-case on-latency is 258 cycles.
- Fade from duty D to 0 takes `ceil(D/FADE_STEP)` fade ticks. The first tick may arrive anywhere within FADE_TICK cycles, because `tick_cnt` is not restarted on ON→FADE.
- `led_in` is synchronous to `clk` (the chaser shares the clock); there is no synchronizer.

## Configuration
- `LED_FADE_EN` defined: behaviour as above. The FADE state, `tick_cnt` and the decrement logic are present.
- `LED_FADE_EN` undefined:
  - FSM is OFF/ON only; ON → OFF directly when `led_in[i]=0`, and `duty` is cleared to 0 in the same cycle.
  - `tick_cnt` is removed.
  - `FADE_TICK`/`FADE_STEP` remain declared but are unused.

## Structure
- Shared package `led_pkg` holds:
  - the channel state encoding (OFF=2'd0, ON=2'd1, FADE=2'd2),
  - `LED_NUM=4`,
  - `PWM_W=8`.
- Sub-module `led_fade_channel` (one instance per channel) contains the FSM, `duty`, `duty_q` and the compare.
- The top holds `pwm_cnt` and `tick_cnt` and fans out `pwm_cnt`, `period_end` and `fade_tick`.

## Test plan
Bench parameters: `FADE_TICK=4`, `FADE_STEP=64`.
- Reset: assert `rst_n=0` mid-period with `led_out` high → `led_out=0000` in the same cycle; hold 10 cycles, release → `led_out` stays 0 while `led_in=0`.
- Duty: `led_in=0001`, `bright=64` → from the second period onward, `led_out[0]` is high for exactly 64 of every 256 cycles, starting at `pwm_cnt==0`+1; other channels stay 0.
- Fade: `bright=255`, ch0 ON, then `led_in=0000` → duty sequence 255, 191, 127, 63, 0 on successive fade ticks; FSM reaches OFF after 4 ticks; `led_out[0]` high-time per period follows the latched values.
- Re-light: `led_in[0]` back to 1 while in FADE at duty 127 → FSM is ON the next cycle, `duty=bright=255`, and `duty_q` takes 255 at the next period end.
- Mid-period change: `bright` changes 64→200 at `pwm_cnt==100` → the current period keeps 64 high cycles and the next period has 200.
- Fade disabled: without `LED_FADE_EN`, ch0 ON at duty 255 then `led_in=0` → `duty=0` the next cycle and `led_out[0]=0` from the following period.
